shfifo_burst_reader: RTL and testbench
======================================

SHFIFO_BURST_READER -- requirements
Module: shfifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: FIFO/stream data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 4: width of the FIFO occupancy count (FIFO_ADDR+1).
REQ-003 SHALL have parameter BURST_LEN, default 4: beats per full burst, range 1..2^(CNT_WIDTH-1).
REQ-004 SHALL have parameter TIMEOUT, default 16: idle cycles before a partial-burst flush, minimum 2.
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port fifo_ren, output, 1: pop strobe to a show-ahead FIFO.
REQ-008 SHALL have port fifo_rdat, input, DATA_WIDTH: FIFO head word, valid in the same cycle while fifo_empty=0.
REQ-009 SHALL have port fifo_empty, input, 1: FIFO empty flag.
REQ-010 SHALL have port fifo_rcnt, input, CNT_WIDTH: FIFO occupancy (registered in the FIFO).
REQ-011 SHALL have port m_valid, output, 1: downstream beat valid.
REQ-012 SHALL have port m_data, output, DATA_WIDTH: downstream beat data.
REQ-013 SHALL have port m_last, output, 1: final beat of the burst.
REQ-014 SHALL have port m_ready, input, 1: downstream accept.
REQ-015 SHALL have port burst_done, output, 1: one-cycle pulse, burst completed.
REQ-016 SHALL have port underrun_err, output, 1: sticky flag, pop attempted on an empty FIFO.

Function
REQ-017 SHALL implement FSM states IDLE, BURST and DRAIN.
REQ-018 IDLE: if fifo_rcnt>=BURST_LEN, SHALL go to BURST with beats_left=BURST_LEN; this check has priority over the timeout.
REQ-019 IDLE: idle_tmr SHALL increment each cycle with 0<fifo_rcnt<BURST_LEN, else clear to 0.
REQ-020 IDLE: idle_tmr==TIMEOUT-1 with 0<fifo_rcnt<BURST_LEN SHALL go to BURST with beats_left=fifo_rcnt, and clear idle_tmr.
REQ-021 Define load = (~m_valid | m_ready).
REQ-022 fifo_ren SHALL be combinational: state==BURST & beats_left!=0 & ~fifo_empty & load.
REQ-023 On fifo_ren, the next edge SHALL register m_data=fifo_rdat, m_valid=1, m_last=(beats_left==1), and decrement beats_left; latency fifo_ren to m_valid is 1 cycle.
REQ-024 When m_valid & m_ready and no pop in the same cycle, the next edge SHALL clear m_valid and m_last.
REQ-025 While m_valid & ~m_ready, m_data and m_last SHALL hold and fifo_ren SHALL be 0.
REQ-026 BURST SHALL go to DRAIN on the edge where beats_left reaches 0.
REQ-027 DRAIN SHALL go to IDLE on m_valid & m_last & m_ready; burst_done SHALL pulse on that same edge.
REQ-028 Full throughput: with m_ready held 1 and the FIFO non-empty, one beat SHALL transfer per cycle.
REQ-029 BURST with beats_left!=0 & fifo_empty SHALL stall with no pop and set underrun_err; underrun_err clears only on reset.
REQ-030 With BURST_LEN=1, every beat SHALL carry m_last=1.
REQ-031 beats_left width SHALL be CNT_WIDTH; comparisons are unsigned.

Reset
REQ-032 Reset asserted SHALL immediately force: state=IDLE, beats_left=0, idle_tmr=0, m_valid=0, m_data=0, m_last=0, burst_done=0, underrun_err=0.
REQ-033 Reset asserted SHALL force fifo_ren=0.
REQ-034 Reset mid-burst SHALL discard the in-flight beat; the first cycle after release SHALL be IDLE.

Configuration
REQ-035 Macro BURST_RD_TIMEOUT_EN defined: partial-burst flush per REQ-019/020 is present.
REQ-036 Macro BURST_RD_TIMEOUT_EN undefined: idle_tmr logic is absent and only full BURST_LEN bursts are issued; words below BURST_LEN stay in the FIFO indefinitely.

Verification
REQ-037 Full burst: BURST_LEN=4, push A0..A3, m_ready=1 -> 4 consecutive beats A0..A3, m_last only on A3, burst_done 1 cycle after A3 accept.
REQ-038 Timeout flush: push 2 words, TIMEOUT=16 -> fifo_ren asserts 17 cycles after occupancy becomes 2, burst of 2 beats, m_last on beat 2; with the macro off -> no beats within 100 cycles.
REQ-039 Backpressure: m_ready=0 for cycles 2-5 of the burst -> m_data/m_last stable, fifo_ren=0 during the stall, no loss or duplication, order preserved.
REQ-040 Back-to-back: push 8 words at once -> two 4-beat bursts, one IDLE cycle between them, two burst_done pulses.
REQ-041 Reset mid-burst: assert rst_n=0 after beat 2 -> m_valid=0 immediately and state IDLE; after release, a new push of 4 words yields a clean 4-beat burst.
REQ-042 Underrun: force fifo_empty=1 with fifo_rcnt=4 -> underrun_err=1 sticky, no fifo_ren, no m_valid.

Source files
------------

// File: rtl/shfifo_burst_reader.sv
// Burst reader that pops a show-ahead FIFO into a valid/ready stream in BURST_LEN-beat bursts.
// Optional partial-burst timeout flush is enabled by defining BURST_RD_TIMEOUT_EN.
`timescale 1ns/1ps
module shfifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdat,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_rcnt,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  burst_done,
    output logic                  underrun_err
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] beats_left;
    logic                 load;
    logic                 pop;
    logic                 full_avail;
    logic                 tmr_fire;

    if (BURST_LEN < 1 || BURST_LEN > (1 << (CNT_WIDTH - 1)) || TIMEOUT < 2) begin : g_bad_param
        $error("shfifo_burst_reader: BURST_LEN or TIMEOUT out of range");
    end

    assign load       = ~m_valid | m_ready;
    assign full_avail = (fifo_rcnt >= CNT_WIDTH'(BURST_LEN));
    assign pop        = rst_n & (state == BURST) & (beats_left != '0) & ~fifo_empty & load;
    assign fifo_ren   = pop;

`ifdef BURST_RD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);

    logic [TMR_W-1:0] idle_tmr;
    logic             partial;

    assign partial  = (fifo_rcnt != '0) && !full_avail;
    assign tmr_fire = (state == IDLE) && partial && (idle_tmr == TMR_W'(TIMEOUT - 1));

    // Timer only runs while a partial burst sits in the FIFO; a full burst always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_tmr <= '0;
        end else if ((state == IDLE) && partial && !tmr_fire) begin
            idle_tmr <= idle_tmr + 1'b1;
        end else begin
            idle_tmr <= '0;
        end
    end
`else
    assign tmr_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beats_left   <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
            burst_done   <= 1'b0;
            underrun_err <= 1'b0;
        end else begin
            burst_done <= 1'b0;

            if ((state == BURST) && (beats_left != '0) && fifo_empty) begin
                underrun_err <= 1'b1;
            end

            // A pop refills the output register in the same edge the old beat leaves.
            if (pop) begin
                m_data     <= fifo_rdat;
                m_valid    <= 1'b1;
                m_last     <= (beats_left == CNT_WIDTH'(1));
                beats_left <= beats_left - 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (full_avail) begin
                        state      <= BURST;
                        beats_left <= CNT_WIDTH'(BURST_LEN);
                    end else if (tmr_fire) begin
                        state      <= BURST;
                        beats_left <= fifo_rcnt;
                    end
                end
                BURST: begin
                    if (pop && (beats_left == CNT_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_valid && m_last && m_ready) begin
                        state      <= IDLE;
                        burst_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shfifo_burst_reader.sv
// Directed self-checking bench for shfifo_burst_reader with a queue-based show-ahead FIFO model.
// Timeout checks follow BURST_RD_TIMEOUT_EN as defined for the build.
`timescale 1ns/1ps
module tb_shfifo_burst_reader;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_ren;
    logic [DW-1:0] fifo_rdat;
    logic          fifo_empty;
    logic [CW-1:0] fifo_rcnt;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          burst_done;
    logic          underrun_err;

    shfifo_burst_reader #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .BURST_LEN (4),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_ren    (fifo_ren),
        .fifo_rdat   (fifo_rdat),
        .fifo_empty  (fifo_empty),
        .fifo_rcnt   (fifo_rcnt),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .burst_done  (burst_done),
        .underrun_err(underrun_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    logic [DW-1:0] rx_data[$];
    logic          rx_last[$];
    int            rx_cyc[$];
    bit            force_empty;

    int checks, failures;
    int cyc, done_cnt, done_cyc, ren_cnt, valid_cnt, first_ren_cyc;
    int stall_ren_err, hold_err, stall_cyc;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic updateFifo();
        fifo_empty = force_empty || (q.size() == 0);
        fifo_rdat  = (q.size() != 0) ? q[0] : '0;
        fifo_rcnt  = force_empty ? CW'(4) : CW'(q.size());
    endtask

    task automatic applyStimulus(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) q.push_back(base + DW'(i));
        updateFifo();
    endtask

    task automatic clearStats();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        cyc = 0; done_cnt = 0; done_cyc = 0; ren_cnt = 0; valid_cnt = 0; first_ren_cyc = 0;
        stall_ren_err = 0; hold_err = 0; stall_cyc = 0; prev_stall = 0;
    endtask

    // One clock: observe at the falling edge, then let the FIFO model react after the rising edge.
    task automatic cycle();
        bit ren_s;
        @(negedge clk);
        cyc++;
        if (fifo_ren) begin
            ren_cnt++;
            if (first_ren_cyc == 0) first_ren_cyc = cyc;
        end
        if (m_valid) valid_cnt++;
        if (burst_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) hold_err++;
        if (m_valid && !m_ready) begin
            stall_cyc++;
            if (fifo_ren) stall_ren_err++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_last.push_back(m_last);
            rx_cyc.push_back(cyc);
        end
        ren_s = fifo_ren;
        @(posedge clk);
        #1;
        if (ren_s && q.size() != 0) q.delete(0);
        updateFifo();
    endtask

    task automatic runUntilDone(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) cycle();
        checkOutput(tag, done_cnt, target);
    endtask

    task automatic checkBeats(input string tag, input int n, input logic [DW-1:0] base,
                              input logic [7:0] last_mask);
        logic [7:0] got_mask;
        got_mask = '0;
        checkOutput({tag, "_count"}, rx_data.size(), n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), rx_data[i], base + DW'(i));
            got_mask[i] = rx_last[i];
        end
        checkOutput({tag, "_last"}, got_mask, last_mask);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bcyc;
        checks = 0;
        failures = 0;
        force_empty = 0;
        rst_n = 1'b0;
        m_ready = 1'b1;
        clearStats();
        updateFifo();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outs", {m_valid, m_last, burst_done, underrun_err, fifo_ren}, 5'b0);
        checkOutput("reset_data", m_data, 0);
        rst_n = 1'b1;

        $display("[TB] full burst");
        clearStats();
        applyStimulus(4, 32'hA0);
        runUntilDone("fb_done", 1, 30);
        checkBeats("fb", 4, 32'hA0, 8'b0000_1000);
        checkOutput("fb_consec", rx_cyc[3] - rx_cyc[0], 3);
        checkOutput("fb_done_lat", done_cyc - rx_cyc[3], 1);
        repeat (2) cycle();

        $display("[TB] back-to-back");
        clearStats();
        applyStimulus(8, 32'hB0);
        runUntilDone("b2b_done", 2, 60);
        checkBeats("b2b", 8, 32'hB0, 8'b1000_1000);
        checkOutput("b2b_gap", rx_cyc[4] - rx_cyc[3], 3);
        repeat (2) cycle();

        $display("[TB] backpressure");
        clearStats();
        applyStimulus(4, 32'hC0);
        bcyc = 0;
        for (int i = 0; i < 40 && done_cnt < 1; i++) begin
            cycle();
            if (bcyc > 0) bcyc++;
            else if (m_valid) bcyc = 1;
            m_ready = !(bcyc >= 2 && bcyc <= 5);
        end
        m_ready = 1'b1;
        checkOutput("bp_done", done_cnt, 1);
        checkBeats("bp", 4, 32'hC0, 8'b0000_1000);
        checkOutput("bp_stall_cycles", stall_cyc, 4);
        checkOutput("bp_stall_ren", stall_ren_err, 0);
        checkOutput("bp_hold", hold_err, 0);
        repeat (2) cycle();

`ifdef BURST_RD_TIMEOUT_EN
        $display("[TB] timeout flush");
        clearStats();
        applyStimulus(2, 32'hD0);
        runUntilDone("to_done", 1, 60);
        checkOutput("to_first_ren", first_ren_cyc, 17);
        checkBeats("to", 2, 32'hD0, 8'b0000_0010);
        repeat (2) cycle();
`else
        $display("[TB] no timeout flush");
        clearStats();
        applyStimulus(2, 32'hD0);
        repeat (100) cycle();
        checkOutput("nto_valid", valid_cnt, 0);
        checkOutput("nto_ren", ren_cnt, 0);
        checkOutput("nto_fifo_left", q.size(), 2);
        q.delete();
        updateFifo();
        cycle();
`endif

        $display("[TB] reset mid-burst");
        clearStats();
        applyStimulus(4, 32'hE0);
        for (int i = 0; i < 20 && rx_data.size() < 2; i++) cycle();
        checkOutput("rm_beats_before", rx_data.size(), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("rm_async", {m_valid, m_last, fifo_ren}, 3'b000);
        q.delete();
        updateFifo();
        repeat (2) cycle();
        rst_n = 1'b1;
        clearStats();
        cycle();
        checkOutput("rm_idle_after", {m_valid, fifo_ren}, 2'b00);
        clearStats();
        applyStimulus(4, 32'hF0);
        runUntilDone("rm_done", 1, 30);
        checkBeats("rm", 4, 32'hF0, 8'b0000_1000);
        repeat (2) cycle();

        $display("[TB] underrun");
        clearStats();
        force_empty = 1;
        updateFifo();
        repeat (10) cycle();
        checkOutput("ur_flag", underrun_err, 1);
        checkOutput("ur_ren", ren_cnt, 0);
        checkOutput("ur_valid", valid_cnt, 0);
        force_empty = 0;
        updateFifo();
        repeat (3) cycle();
        checkOutput("ur_sticky", underrun_err, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("ur_reset_clear", underrun_err, 0);
        rst_n = 1'b1;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
